// File: rtl/layer_layout_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : layer_layout_ctrl_if                                            |
// | Purpose  : Bundles the layout-request handshake, frame timing inputs and   |
// |            the per-layer window/alpha settings of layer_layout_ctrl.       |
// | Ports    : master = requester / consumer side, slave = controller side.    |
// |            vs, h_active, v_active, cfg_valid/mode/main/sub  -> controller  |
// |            cfg_ready, busy, done, layerN_top/left/width/height/alpha <-    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface layer_layout_ctrl_if;
  logic        vs;
  logic [11:0] h_active;
  logic [11:0] v_active;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic [1:0]  cfg_main;
  logic [1:0]  cfg_sub;
  logic        busy;
  logic        done;
  logic [11:0] layer0_top, layer1_top, layer2_top, layer3_top;
  logic [11:0] layer0_left, layer1_left, layer2_left, layer3_left;
  logic [11:0] layer0_width, layer1_width, layer2_width, layer3_width;
  logic [11:0] layer0_height, layer1_height, layer2_height, layer3_height;
  logic [7:0]  layer0_alpha, layer1_alpha, layer2_alpha, layer3_alpha;

  modport master (
    output vs, h_active, v_active, cfg_valid, cfg_mode, cfg_main, cfg_sub,
    input  cfg_ready, busy, done,
    input  layer0_top, layer1_top, layer2_top, layer3_top,
    input  layer0_left, layer1_left, layer2_left, layer3_left,
    input  layer0_width, layer1_width, layer2_width, layer3_width,
    input  layer0_height, layer1_height, layer2_height, layer3_height,
    input  layer0_alpha, layer1_alpha, layer2_alpha, layer3_alpha
  );

  modport slave (
    input  vs, h_active, v_active, cfg_valid, cfg_mode, cfg_main, cfg_sub,
    output cfg_ready, busy, done,
    output layer0_top, layer1_top, layer2_top, layer3_top,
    output layer0_left, layer1_left, layer2_left, layer3_left,
    output layer0_width, layer1_width, layer2_width, layer3_width,
    output layer0_height, layer1_height, layer2_height, layer3_height,
    output layer0_alpha, layer1_alpha, layer2_alpha, layer3_alpha
  );
endinterface
`default_nettype wire

// File: rtl/layer_layout_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : layer_layout_ctrl                                               |
// | Purpose  : Sequences layout changes (QUAD / SINGLE / PIP / OFF) for the    |
// |            four-layer blend chain. Each change is a frame-synchronous      |
// |            fade-out, geometry swap, fade-in so geometry never moves        |
// |            mid-frame.                                                      |
// | Ports    : dp_clk  pixel clock                                             |
// |            rst     asynchronous reset, active-high                         |
// |            bus     layer_layout_ctrl_if.slave (request, timing, settings)  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module layer_layout_ctrl #(
  parameter logic [7:0]  FADE_STEP  = 8'd16,
  parameter int          PIP_SHIFT  = 2,
  parameter logic [11:0] PIP_MARGIN = 12'd16
) (
  input wire                 dp_clk,
  input wire                 rst,
  layer_layout_ctrl_if.slave bus
);

  localparam logic [1:0] c_mode_quad   = 2'd0;
  localparam logic [1:0] c_mode_single = 2'd1;
  localparam logic [1:0] c_mode_pip    = 2'd2;
  localparam logic [1:0] c_mode_off    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FADE_OUT = 2'd1,
    S_SWAP     = 2'd2,
    S_FADE_IN  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        vs_dly_q, vs_dly_d;
  logic [7:0]  g_q, g_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  pend_mode_q, pend_mode_d;
  logic [1:0]  pend_main_q, pend_main_d;
  logic [1:0]  pend_sub_q, pend_sub_d;
  logic [3:0]  vis_q, vis_d;
  logic        done_q, done_d;
  logic [11:0] top_q [4], top_d [4];
  logic [11:0] left_q [4], left_d [4];
  logic [11:0] width_q [4], width_d [4];
  logic [11:0] height_q [4], height_d [4];
  logic [7:0]  alpha_q [4], alpha_d [4];

  logic        tick;
  logic        swap;
  logic [8:0]  fade_sum;

  // Layout derived from the pending request and the frame size seen now.
  logic [1:0]  eff_mode;
  logic [11:0] half_w, half_h, pip_w, pip_h, pip_left;
  logic [12:0] pip_left_wide;
  logic [3:0]  lay_vis;
  logic [11:0] lay_top [4], lay_left [4], lay_width [4], lay_height [4];

  assign vs_dly_d = bus.vs;
  assign tick     = bus.vs & ~vs_dly_q;
  assign fade_sum = {1'b0, g_q} + {1'b0, FADE_STEP};

  always_comb begin
    eff_mode = pend_mode_q;
    // Higher index blends on top; an inset at or below the main layer would
    // be fully covered, so show the main layer alone.
    if ((pend_mode_q == c_mode_pip) && (pend_sub_q <= pend_main_q)) begin
      eff_mode = c_mode_single;
    end
    half_w        = bus.h_active >> 1;
    half_h        = bus.v_active >> 1;
    pip_w         = bus.h_active >> PIP_SHIFT;
    pip_h         = bus.v_active >> PIP_SHIFT;
    pip_left_wide = {1'b0, bus.h_active - pip_w} - {1'b0, PIP_MARGIN};
    pip_left      = pip_left_wide[12] ? 12'd0 : pip_left_wide[11:0];
    lay_vis       = 4'd0;
    for (int i = 0; i < 4; i++) begin
      lay_top[i]    = 12'd0;
      lay_left[i]   = 12'd0;
      lay_width[i]  = 12'd0;
      lay_height[i] = 12'd0;
    end
    case (eff_mode)
      c_mode_quad: begin
        lay_vis = 4'hF;
        for (int i = 0; i < 4; i++) begin
          lay_top[i]    = (i >= 2) ? half_h : 12'd0;
          lay_left[i]   = ((i & 1) != 0) ? half_w : 12'd0;
          lay_width[i]  = half_w;
          lay_height[i] = half_h;
        end
      end
      c_mode_single, c_mode_pip: begin
        lay_vis[pend_main_q]    = 1'b1;
        lay_width[pend_main_q]  = bus.h_active;
        lay_height[pend_main_q] = bus.v_active;
        if (eff_mode == c_mode_pip) begin
          lay_vis[pend_sub_q]    = 1'b1;
          lay_top[pend_sub_q]    = PIP_MARGIN;
          lay_left[pend_sub_q]   = pip_left;
          lay_width[pend_sub_q]  = pip_w;
          lay_height[pend_sub_q] = pip_h;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    mode_d      = mode_q;
    pend_mode_d = pend_mode_q;
    pend_main_d = pend_main_q;
    pend_sub_d  = pend_sub_q;
    vis_d       = vis_q;
    done_d      = 1'b0;
    swap        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_valid) begin
          pend_mode_d = bus.cfg_mode;
          pend_main_d = bus.cfg_main;
          pend_sub_d  = bus.cfg_sub;
          state_d     = S_FADE_OUT;
        end
      end
      S_FADE_OUT: begin
        if (g_q == 8'd0) begin
          state_d = S_SWAP;
        end else if (tick) begin
          g_d = (g_q < FADE_STEP) ? 8'd0 : g_q - FADE_STEP;
          if (g_d == 8'd0) state_d = S_SWAP;
        end
      end
      S_SWAP: begin
        if (tick) begin
          swap    = 1'b1;
          mode_d  = eff_mode;
          vis_d   = lay_vis;
          state_d = S_FADE_IN;
        end
      end
      S_FADE_IN: begin
        // Nothing is visible in OFF, so there is nothing to fade in.
        if (mode_q == c_mode_off) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tick) begin
          g_d = fade_sum[8] ? 8'hFF : fade_sum[7:0];
          if (g_d == 8'hFF) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      top_d[i]    = swap ? lay_top[i]    : top_q[i];
      left_d[i]   = swap ? lay_left[i]   : left_q[i];
      width_d[i]  = swap ? lay_width[i]  : width_q[i];
      height_d[i] = swap ? lay_height[i] : height_q[i];
      alpha_d[i]  = vis_d[i] ? g_d : 8'd0;
    end
  end

  always_ff @(posedge dp_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vs_dly_q    <= 1'b1;  // vs already high at reset release is not an edge
      g_q         <= 8'd0;
      mode_q      <= c_mode_off;
      pend_mode_q <= c_mode_off;
      pend_main_q <= 2'd0;
      pend_sub_q  <= 2'd0;
      vis_q       <= 4'd0;
      done_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        top_q[i]    <= 12'd0;
        left_q[i]   <= 12'd0;
        width_q[i]  <= 12'd0;
        height_q[i] <= 12'd0;
        alpha_q[i]  <= 8'd0;
      end
    end else begin
      state_q     <= state_d;
      vs_dly_q    <= vs_dly_d;
      g_q         <= g_d;
      mode_q      <= mode_d;
      pend_mode_q <= pend_mode_d;
      pend_main_q <= pend_main_d;
      pend_sub_q  <= pend_sub_d;
      vis_q       <= vis_d;
      done_q      <= done_d;
      for (int i = 0; i < 4; i++) begin
        top_q[i]    <= top_d[i];
        left_q[i]   <= left_d[i];
        width_q[i]  <= width_d[i];
        height_q[i] <= height_d[i];
        alpha_q[i]  <= alpha_d[i];
      end
    end
  end

  assign bus.cfg_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;

  assign bus.layer0_top    = top_q[0];
  assign bus.layer1_top    = top_q[1];
  assign bus.layer2_top    = top_q[2];
  assign bus.layer3_top    = top_q[3];
  assign bus.layer0_left   = left_q[0];
  assign bus.layer1_left   = left_q[1];
  assign bus.layer2_left   = left_q[2];
  assign bus.layer3_left   = left_q[3];
  assign bus.layer0_width  = width_q[0];
  assign bus.layer1_width  = width_q[1];
  assign bus.layer2_width  = width_q[2];
  assign bus.layer3_width  = width_q[3];
  assign bus.layer0_height = height_q[0];
  assign bus.layer1_height = height_q[1];
  assign bus.layer2_height = height_q[2];
  assign bus.layer3_height = height_q[3];
  assign bus.layer0_alpha  = alpha_q[0];
  assign bus.layer1_alpha  = alpha_q[1];
  assign bus.layer2_alpha  = alpha_q[2];
  assign bus.layer3_alpha  = alpha_q[3];

endmodule
`default_nettype wire

// File: tb/tb_layer_layout_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_layer_layout_ctrl                                            |
// | Purpose  : Self-checking bench for layer_layout_ctrl. Expected alpha/done  |
// |            per frame tick is queued when a request is driven and compared  |
// |            as each tick is applied; geometry is compared at the swap.      |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_layer_layout_ctrl;

  localparam logic [1:0] c_quad   = 2'd0;
  localparam logic [1:0] c_single = 2'd1;
  localparam logic [1:0] c_pip    = 2'd2;
  localparam logic [1:0] c_off    = 2'd3;

  typedef struct packed {
    logic [31:0] alpha;
    logic        done;
  } exp_t;

  logic dp_clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t        sb_q [$];
  logic [7:0]  m_g;
  logic [3:0]  m_vis;
  logic [47:0] m_geom [4];

  layer_layout_ctrl_if bus ();

  layer_layout_ctrl dut (
    .dp_clk (dp_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 dp_clk = ~dp_clk;

  function automatic logic [31:0] obs_alpha();
    return {bus.layer3_alpha, bus.layer2_alpha, bus.layer1_alpha, bus.layer0_alpha};
  endfunction

  function automatic logic [47:0] obs_geom(input int i);
    case (i)
      0: return {bus.layer0_top, bus.layer0_left, bus.layer0_width, bus.layer0_height};
      1: return {bus.layer1_top, bus.layer1_left, bus.layer1_width, bus.layer1_height};
      2: return {bus.layer2_top, bus.layer2_left, bus.layer2_width, bus.layer2_height};
      default: return {bus.layer3_top, bus.layer3_left, bus.layer3_width, bus.layer3_height};
    endcase
  endfunction

  function automatic logic [31:0] m_alpha();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) a[i*8 +: 8] = m_vis[i] ? m_g : 8'd0;
    return a;
  endfunction

  // Reference layout written directly from the layout rules.
  task automatic model_layout(input logic [1:0] mode, input logic [1:0] main_l,
                              input logic [1:0] sub_l, input logic [11:0] w,
                              input logic [11:0] h);
    logic [11:0] hw, hh, qw, qh;
    int          lft;
    hw = 12'(w / 2);
    hh = 12'(h / 2);
    qw = 12'(w / 4);
    qh = 12'(h / 4);
    m_vis = 4'd0;
    for (int i = 0; i < 4; i++) m_geom[i] = 48'd0;
    if (mode == c_pip && sub_l <= main_l) mode = c_single;
    if (mode == c_quad) begin
      m_vis = 4'hF;
      for (int i = 0; i < 4; i++)
        m_geom[i] = {(i >= 2) ? hh : 12'd0, (i % 2 == 1) ? hw : 12'd0, hw, hh};
    end else if (mode == c_single || mode == c_pip) begin
      m_vis[main_l]  = 1'b1;
      m_geom[main_l] = {12'd0, 12'd0, w, h};
      if (mode == c_pip) begin
        lft = int'(w) - int'(qw) - 16;
        if (lft < 0) lft = 0;
        m_vis[sub_l]  = 1'b1;
        m_geom[sub_l] = {12'd16, 12'(lft), qw, qh};
      end
    end
  endtask

  task automatic do_tick(output logic done_seen);
    @(negedge dp_clk);
    bus.vs = 1'b1;
    @(negedge dp_clk);
    done_seen = bus.done;
    bus.vs = 1'b0;
    @(negedge dp_clk);
  endtask

  task automatic send_req(input logic [1:0] mode, input logic [1:0] main_l,
                          input logic [1:0] sub_l);
    @(negedge dp_clk);
    n_tests++;
    if (bus.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_req: got %b expected 1", bus.cfg_ready);
    end
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = mode;
    bus.cfg_main  = main_l;
    bus.cfg_sub   = sub_l;
    @(negedge dp_clk);
    bus.cfg_valid = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL req_accept: busy got %b expected 1", bus.busy);
    end
  endtask

  // Full change sequence; optional held request raised during the fade-in.
  task automatic run_sequence(input logic [1:0] mode, input logic [1:0] main_l,
                              input logic [1:0] sub_l, input logic [11:0] w,
                              input logic [11:0] h, input bit skip_req,
                              input bit hold, input logic [1:0] hold_mode,
                              input logic [1:0] hold_main);
    exp_t e;
    logic d;
    int   swap_idx;
    int   k;
    bus.h_active = w;
    bus.v_active = h;
    if (!skip_req) send_req(mode, main_l, sub_l);
    while (m_g != 8'd0) begin
      m_g = (m_g < 8'd16) ? 8'd0 : m_g - 8'd16;
      e.alpha = m_alpha();
      e.done  = 1'b0;
      sb_q.push_back(e);
    end
    model_layout(mode, main_l, sub_l, w, h);
    swap_idx = sb_q.size();
    e.alpha  = m_alpha();
    e.done   = 1'b0;
    sb_q.push_back(e);
    if (mode != c_off) begin
      while (m_g != 8'hFF) begin
        m_g = (m_g > 8'd239) ? 8'hFF : m_g + 8'd16;
        e.alpha = m_alpha();
        e.done  = (m_g == 8'hFF);
        sb_q.push_back(e);
      end
    end
    k = 0;
    while (sb_q.size() > 0) begin
      if (hold && k > swap_idx) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_mode  = hold_mode;
        bus.cfg_main  = hold_main;
        bus.cfg_sub   = 2'd0;
      end
      do_tick(d);
      e = sb_q.pop_front();
      n_tests++;
      if (obs_alpha() !== e.alpha || d !== e.done) begin
        n_fail++;
        $display("FAIL tick%0d_alpha_done: got %h/%b expected %h/%b",
                 k, obs_alpha(), d, e.alpha, e.done);
      end
      if (hold && k > swap_idx && !e.done) begin
        n_tests++;
        if (bus.cfg_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL held_ready: got %b expected 0", bus.cfg_ready);
        end
      end
      if (k == swap_idx) begin
        for (int i = 0; i < 4; i++) begin
          n_tests++;
          if (obs_geom(i) !== m_geom[i]) begin
            n_fail++;
            $display("FAIL swap_geom_layer%0d: got %h expected %h", i, obs_geom(i), m_geom[i]);
          end
        end
      end
      k++;
    end
    n_tests++;
    if (hold) begin
      bus.cfg_valid = 1'b0;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL held_accept: busy got %b expected 1", bus.busy);
      end
    end else if (mode == c_off) begin
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL off_done: done/busy got %b/%b expected 1/0", bus.done, bus.busy);
      end
    end else begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_end: done/busy got %b/%b expected 0/0", bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.vs = 1'b1;
    repeat (3) @(negedge dp_clk);
    rst = 1'b0;
    repeat (3) @(negedge dp_clk);
    n_tests++;
    if (obs_alpha() !== 32'd0 || bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: alpha/ready/busy/done got %h/%b/%b/%b expected 0/1/0/0",
               obs_alpha(), bus.cfg_ready, bus.busy, bus.done);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (obs_geom(i) !== 48'd0) begin
        n_fail++;
        $display("FAIL reset_geom_layer%0d: got %h expected 0", i, obs_geom(i));
      end
    end
    bus.vs = 1'b0;
    m_g = 8'd0;
    m_vis = 4'd0;
  endtask

  task automatic test_quad();
    run_sequence(c_quad, 2'd0, 2'd0, 12'd1920, 12'd1080, 1'b0, 1'b0, 2'd0, 2'd0);
    n_tests++;
    if (obs_geom(3) !== {12'd540, 12'd960, 12'd960, 12'd540} || obs_alpha() !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL quad_layer3: got %h/%h expected %h/ffffffff",
               obs_geom(3), obs_alpha(), {12'd540, 12'd960, 12'd960, 12'd540});
    end
  endtask

  task automatic test_pip();
    run_sequence(c_pip, 2'd0, 2'd2, 12'd1920, 12'd1080, 1'b0, 1'b0, 2'd0, 2'd0);
    n_tests++;
    if (obs_geom(2) !== {12'd16, 12'd1424, 12'd480, 12'd270} ||
        obs_geom(0) !== {12'd0, 12'd0, 12'd1920, 12'd1080} ||
        obs_geom(1) !== 48'd0 || obs_geom(3) !== 48'd0) begin
      n_fail++;
      $display("FAIL pip_geom: l0 %h l1 %h l2 %h l3 %h", obs_geom(0), obs_geom(1),
               obs_geom(2), obs_geom(3));
    end
  endtask

  task automatic test_pip_degrade();
    run_sequence(c_pip, 2'd3, 2'd1, 12'd1920, 12'd1080, 1'b0, 1'b0, 2'd0, 2'd0);
    n_tests++;
    if (obs_geom(1) !== 48'd0 || bus.layer1_alpha !== 8'd0 ||
        obs_geom(3) !== {12'd0, 12'd0, 12'd1920, 12'd1080} || bus.layer3_alpha !== 8'hFF) begin
      n_fail++;
      $display("FAIL pip_degrade: l1 %h a1 %h l3 %h a3 %h", obs_geom(1), bus.layer1_alpha,
               obs_geom(3), bus.layer3_alpha);
    end
  endtask

  task automatic test_pip_clamp();
    run_sequence(c_pip, 2'd1, 2'd3, 12'd20, 12'd8, 1'b0, 1'b0, 2'd0, 2'd0);
    n_tests++;
    if (obs_geom(3) !== {12'd16, 12'd0, 12'd5, 12'd2}) begin
      n_fail++;
      $display("FAIL pip_clamp: got %h expected %h", obs_geom(3), {12'd16, 12'd0, 12'd5, 12'd2});
    end
  endtask

  task automatic test_off();
    run_sequence(c_off, 2'd0, 2'd0, 12'd1920, 12'd1080, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic test_back_to_back();
    run_sequence(c_quad, 2'd0, 2'd0, 12'd1920, 12'd1080, 1'b0, 1'b1, c_single, 2'd1);
    run_sequence(c_single, 2'd1, 2'd0, 12'd1920, 12'd1080, 1'b1, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic test_async_reset();
    logic d;
    bus.h_active = 12'd1920;
    bus.v_active = 12'd1080;
    send_req(c_pip, 2'd0, 2'd2);
    for (int k = 0; k < 8; k++) begin
      do_tick(d);
      m_g = m_g - 8'd16;
    end
    n_tests++;
    if (bus.layer1_alpha !== 8'd127 || obs_alpha() !== m_alpha()) begin
      n_fail++;
      $display("FAIL fade_out_127: got %h expected layer1 7f (%h)", obs_alpha(), m_alpha());
    end
    @(negedge dp_clk);
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (obs_alpha() !== 32'd0 || obs_geom(1) !== 48'd0 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: alpha %h geom1 %h busy %b ready %b", obs_alpha(),
               obs_geom(1), bus.busy, bus.cfg_ready);
    end
    @(negedge dp_clk);
    rst = 1'b0;
    m_g = 8'd0;
    m_vis = 4'd0;
    test_quad();
  endtask

  initial begin
    rst           = 1'b1;
    bus.vs        = 1'b1;
    bus.h_active  = 12'd1920;
    bus.v_active  = 12'd1080;
    bus.cfg_valid = 1'b0;
    bus.cfg_mode  = 2'd0;
    bus.cfg_main  = 2'd0;
    bus.cfg_sub   = 2'd0;
    test_reset();
    test_quad();
    test_pip();
    test_pip_degrade();
    test_off();
    test_pip_clamp();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/layer_layout_ctrl.md
Name: layer_layout_ctrl

Overview:
- Sequences layout changes for the four-layer blend chain that feeds the YCbCr-to-RGB output stage.
- Takes one layout request at a time: QUAD 2x2, SINGLE full-screen, PIP, or OFF.
- Generates the per-layer top/left/width/height/alpha settings.
- Every change is applied frame-synchronously with a fade-out, geometry swap, fade-in sequence, so geometry never changes mid-frame.

Parameters:
- FADE_STEP, 8'd16, alpha change per frame tick during fades.
- PIP_SHIFT, 2, PIP window size = active size >> PIP_SHIFT.
- PIP_MARGIN, 12'd16, PIP window offset from the top edge and the right edge.

Ports:
- dp_clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- vs  in  1  vertical sync from the display timing generator, active-high.
- h_active  in  12  active pixels per line.
- v_active  in  12  active lines per frame.
- cfg_valid  in  1  layout request valid.
- cfg_ready  out  1  controller can accept a request.
- cfg_mode  in  2  requested mode: 0 QUAD, 1 SINGLE, 2 PIP, 3 OFF.
- cfg_main  in  2  full-screen layer for SINGLE/PIP.
- cfg_sub  in  2  PIP inset layer.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when a sequence completes.
- layer0_top..layer3_top  out  12 each  window top.
- layer0_left..layer3_left  out  12 each  window left.
- layer0_width..layer3_width  out  12 each  window width.
- layer0_height..layer3_height  out  12 each  window height.
- layer0_alpha..layer3_alpha  out  8 each  layer alpha.

Behaviour:
- Frame tick: vs_d is a register of vs; tick = vs & ~vs_d. vs_d resets to 1 so vs high at reset release gives no tick.
- Reset values:
  - state IDLE, global level g = 0.
  - Active mode register = OFF.
  - All geometry and alpha outputs 0.
  - cfg_ready = 1, busy = 0, done = 0.
- Handshake: cfg_ready = (state == IDLE). A request is accepted when cfg_valid && cfg_ready. On acceptance, cfg_mode/main/sub latch into pending registers and the state becomes FADE_OUT on the next cycle. cfg_valid in other states is ignored. A tick in the acceptance cycle is ignored.
- FADE_OUT:
  - If g == 0, go to SWAP on the next cycle.
  - Otherwise, each tick sets g = (g < FADE_STEP) ? 0 : g - FADE_STEP. The tick that makes g 0 moves the state to SWAP.
- SWAP: on the next tick, geometry registers load the pending layout, the active mode is updated, and the state goes to FADE_IN. Geometry is computed from h_active/v_active as sampled in that cycle.
- FADE_IN:
  - Each tick sets g = min(g + FADE_STEP, 255), using a 9-bit sum with saturation.
  - The tick that makes g 255 returns the state to IDLE and pulses done for one cycle.
  - If the active mode is OFF, go to IDLE immediately (pulse done) and leave g at 0.
- busy = (state != IDLE).
- Alpha: layerN_alpha = g if layer N is visible in the active layout, else 0. Alpha registers update in the same cycle as g.
- Geometry: W = h_active, H = v_active. Hidden layers have top = left = width = height = 0.
  - QUAD: layer i has width W>>1 and height H>>1; left = i[0] ? W>>1 : 0; top = i[1] ? H>>1 : 0. All four layers visible.
  - SINGLE: layer cfg_main at top 0, left 0, width W, height H. Other layers hidden.
  - PIP:
    - Main layer as in SINGLE.
    - Sub layer: width W>>PIP_SHIFT, height H>>PIP_SHIFT, top PIP_MARGIN, left W - (W>>PIP_SHIFT) - PIP_MARGIN, clamped to 0 on underflow.
    - If cfg_sub <= cfg_main, the sub layer would sit under the main layer (higher index is on top), so PIP degrades to SINGLE.
  - OFF: all layers hidden, background only.
- Outputs hold steady between updates. Geometry changes only in SWAP at a tick, and alpha changes only at ticks.
- Asynchronous reset mid-sequence returns everything to the reset values immediately. Any pending request is discarded.

Test Plan:
- Reset with vs held high, then release -> no tick. All outputs 0, cfg_ready = 1, busy = 0.
- From reset, request QUAD with W = 1920, H = 1080:
  - FADE_OUT is skipped; SWAP on the first tick.
  - Layer3 becomes top 540, left 960, width 960, height 540.
  - Alphas reach 255 after 16 further ticks, with done pulsing once.
- From QUAD at g = 255, request PIP main = 0, sub = 2:
  - g steps 239, 223, ..., 15, 0 over 16 ticks.
  - SWAP on tick 17: layer0 is 0/0/1920/1080; layer2 is top 16, left 1424, width 480, height 270; layers 1 and 3 are zeroed.
  - Fade-in takes 16 ticks.
- Request PIP main = 3, sub = 1 -> result is identical to SINGLE layer 3. Layer1 alpha and geometry are 0.
- cfg_valid held during FADE_IN with a different mode -> cfg_ready = 0 and the request is not latched. After done, the held request is accepted in the next cycle.
- Assert rst during FADE_OUT at g = 127 -> next edge shows all outputs 0 and state IDLE. The following request behaves as in the "from reset" scenario.
